// File: rtl/min_calc_pkg.sv
// rtl/min_calc_pkg.sv - shared types and defaults for the serial minimum finder
package min_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_COUNT     = 4;
    localparam int DEF_OUT_WIDTH = 8;

endpackage

// File: rtl/comparator_4b.sv
// rtl/comparator_4b.sv - unsigned 4-bit magnitude comparator, less-than flag
module comparator_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       lt
);

    assign lt = (a < b);

endmodule

// File: rtl/min_update_2num.sv
// rtl/min_update_2num.sv - keeps the smaller of candidate and best; ties keep best
module min_update_2num #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [WIDTH-1:0]     cand,
    input  logic [WIDTH-1:0]     best,
    input  logic [IDX_WIDTH-1:0] cand_idx,
    input  logic [IDX_WIDTH-1:0] best_idx,
    output logic [WIDTH-1:0]     new_best,
    output logic [IDX_WIDTH-1:0] new_idx
);

    logic cand_lt;

    generate
        if (WIDTH == 4) begin : g_cmp4
            comparator_4b u_cmp (
                .a  (cand),
                .b  (best),
                .lt (cand_lt)
            );
        end else begin : g_cmpn
            assign cand_lt = (cand < best);
        end
    endgenerate

    // Strict less-than so an equal later value never displaces the earlier index.
    assign new_best = cand_lt ? cand     : best;
    assign new_idx  = cand_lt ? cand_idx : best_idx;

endmodule

// File: rtl/min_calculator_serial.sv
// rtl/min_calculator_serial.sv - streams COUNT numbers in, reports running minimum and index
module min_calculator_serial
    import min_calc_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int COUNT     = DEF_COUNT,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int IDX_WIDTH = $clog2(COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [OUT_WIDTH-1:0] min,
    output logic [IDX_WIDTH-1:0] min_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(COUNT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_WIDTH-1:0] count;
    logic [WIDTH-1:0]     best;
    logic [IDX_WIDTH-1:0] best_idx;
    logic [WIDTH-1:0]     cmp_best;
    logic [IDX_WIDTH-1:0] cmp_idx;
    logic [WIDTH-1:0]     upd_best;
    logic [IDX_WIDTH-1:0] upd_idx;
    logic                 accept;
    logic                 is_last;
    logic                 frame_start;

    assign accept      = in_valid && in_ready;
    assign is_last     = (count == LAST_IDX);
    assign frame_start = start && ((state == IDLE) || (state == DONE));

    min_update_2num #(
        .WIDTH     (WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_update (
        .cand     (in_data),
        .best     (best),
        .cand_idx (count),
        .best_idx (best_idx),
        .new_best (cmp_best),
        .new_idx  (cmp_idx)
    );

    // The first element of a frame seeds best regardless of stale contents.
    assign upd_best = (count == '0) ? in_data : cmp_best;
    assign upd_idx  = (count == '0) ? '0      : cmp_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && is_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            best     <= '0;
            best_idx <= '0;
            min      <= '0;
            min_idx  <= '0;
        end else begin
            if (frame_start) begin
                count <= '0;
            end
            if (accept) begin
                best     <= upd_best;
                best_idx <= upd_idx;
                count    <= count + IDX_WIDTH'(1);
                if (is_last) begin
                    min     <= OUT_WIDTH'(upd_best);
                    min_idx <= upd_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_min_calculator_serial.sv
// tb/tb_min_calculator_serial.sv - scoreboard bench for min_calculator_serial
module tb_min_calculator_serial;

    localparam int WIDTH     = 4;
    localparam int COUNT     = 4;
    localparam int OUT_WIDTH = 8;
    localparam int IDX_WIDTH = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [OUT_WIDTH-1:0] min;
    logic [IDX_WIDTH-1:0] min_idx;
    logic                 busy;
    logic                 done;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] m;
        logic [IDX_WIDTH-1:0] i;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           held;
    int             n_cmp     = 0;
    int             n_bad     = 0;
    int             cyc       = 0;
    int             last_done = -100;
    int             prev_done = -100;
    logic [WIDTH-1:0] fr[COUNT];

    min_calculator_serial #(
        .WIDTH     (WIDTH),
        .COUNT     (COUNT),
        .OUT_WIDTH (OUT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .min      (min),
        .min_idx  (min_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: smallest value of the frame, reported at its first occurrence.
    function automatic exp_t model();
        exp_t r;
        int   m;
        int   idx;
        m = 1 << WIDTH;
        foreach (fr[k]) if (int'(fr[k]) < m) m = int'(fr[k]);
        idx = -1;
        foreach (fr[k]) if (idx < 0 && int'(fr[k]) == m) idx = k;
        r.m = OUT_WIDTH'(m);
        r.i = IDX_WIDTH'(idx);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_eq_ready", int'(busy), int'(in_ready));
            if (done) begin
                exp_t e;
                chk("ready_low_in_done", int'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("min", int'(min), int'(e.m));
                    chk("min_idx", int'(min_idx), int'(e.i));
                    held      = e;
                    prev_done = last_done;
                    last_done = cyc;
                end
            end else begin
                chk("min_hold", int'(min), int'(held.m));
                chk("min_idx_hold", int'(min_idx), int'(held.i));
            end
        end
    end

    task automatic feed_one(input logic [WIDTH-1:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    task automatic send_frame(input int gap_min, input int gap_max, input bit do_start,
                              input bit chain, input int mid_start_at);
        exp_q.push_back(model());
        if (do_start) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < COUNT; k++) begin
            if (k == mid_start_at) start = 1'b1;
            feed_one(fr[k]);
            start = 1'b0;
            if (k < COUNT - 1) begin
                repeat ($urandom_range(gap_min, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
        end
        if (chain) start = 1'b1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        held     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_min", int'(min), 0);
        chk("rst_min_idx", int'(min_idx), 0);
        @(posedge clk); #1;

        fr = '{4'd7, 4'd2, 4'd9, 4'd5};
        send_frame(0, 0, 1'b1, 1'b0, -1);
        wait_done();

        fr = '{4'd0, 4'd0, 4'd15, 4'd0};
        send_frame(0, 1, 1'b1, 1'b0, -1);
        wait_done();
        fr = '{4'd15, 4'd15, 4'd15, 4'd15};
        send_frame(0, 1, 1'b1, 1'b0, -1);
        wait_done();

        fr = '{4'd8, 4'd8, 4'd1, 4'd4};
        send_frame(3, 3, 1'b1, 1'b0, -1);
        wait_done();

        fr = '{4'd3, 4'd4, 4'd5, 4'd6};
        send_frame(0, 0, 1'b1, 1'b1, -1);
        fr = '{4'd12, 4'd10, 4'd11, 4'd1};
        send_frame(0, 0, 1'b0, 1'b0, -1);
        wait_done();
        chk("b2b_done_spacing", last_done - prev_done, COUNT + 1);

        fr = '{4'd5, 4'd1, 4'd7, 4'd2};
        send_frame(0, 0, 1'b1, 1'b0, 1);
        wait_done();
        repeat (8) begin
            @(posedge clk); #1;
        end

        in_valid = 1'b1;
        in_data  = 4'd0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid_busy", int'(busy), 0);
            chk("idle_valid_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed_one(4'd9);
        feed_one(4'd3);
        rst  = 1'b1;
        held = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_min", int'(min), 0);
        chk("midrst_min_idx", int'(min_idx), 0);
        @(posedge clk); #1;
        fr = '{4'd6, 4'd5, 4'd4, 4'd3};
        send_frame(0, 0, 1'b1, 1'b0, -1);
        wait_done();

        for (int f = 0; f < 24; f++) begin
            int hi;
            hi = (f % 3 == 0) ? 3 : 15;
            foreach (fr[k]) fr[k] = WIDTH'($urandom_range(0, hi));
            send_frame(0, 2, 1'b1, 1'b0, -1);
            wait_done();
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
